// File: rtl/sd_sec_stream.sv
// sd_sec_stream: multi-sector SD read sequencer feeding a valid/ready stream through a sector-sized FIFO.
// Optional SD_SEC_STREAM_BSWAP_EN byte-reverses each 32-bit word at FIFO write.
module sd_sec_stream #(
    parameter int DW        = 32,
    parameter int FIFO_AW   = 8,
    parameter int SEC_WORDS = 128
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_sec_addr,
    input  logic [15:0]       req_sec_cnt,
    output logic              rd_start_en,
    output logic [31:0]       rd_sec_addr,
    input  logic              rd_busy,
    input  logic              rd_val_en,
    input  logic [DW-1:0]     rd_val_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic              m_last,
    output logic              xfer_done,
    output logic              err,
    output logic [FIFO_AW:0]  fifo_level
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [2:0] {IDLE, SPACE, START, WAIT, DONE} state_t;
    state_t state, state_n;
    logic               alive;
    logic [31:0]        cur_addr;
    logic [15:0]        sec_left;
    logic [7:0]         word_cnt;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [DW:0]        mem [DEPTH];
    logic [DW-1:0]      din;
    logic               accept, space_ok, sec_end, push, pop, full, mem_empty, load, bypass, last_in;
`ifdef SD_SEC_STREAM_BSWAP_EN
    assign din = {rd_val_data[7:0], rd_val_data[15:8], rd_val_data[23:16], rd_val_data[31:24]};
`else
    assign din = rd_val_data;
`endif
    assign accept    = req_valid && req_ready;
    assign space_ok  = ((FIFO_AW+1)'(DEPTH) - fifo_level) >= (FIFO_AW+1)'(SEC_WORDS);
    assign sec_end   = state == WAIT && !rd_busy;
    assign full      = fifo_level == (FIFO_AW+1)'(DEPTH);
    assign push      = rd_val_en && !full;
    assign pop       = m_valid && m_ready;
    // The output register counts toward fifo_level, so the memory is empty when only it is occupied.
    assign mem_empty = fifo_level == (FIFO_AW+1)'(m_valid);
    assign load      = !m_valid || pop;
    assign bypass    = push && load && mem_empty;
    assign last_in   = sec_left == 16'd1 && word_cnt == 8'(SEC_WORDS - 1);
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n     = state;
        req_ready   = alive && state == IDLE;
        rd_start_en = state == START;
        xfer_done   = state == DONE;
        case (state)
            IDLE:    state_n = accept ? (req_sec_cnt == 16'd0 ? DONE : SPACE) : IDLE;
            SPACE:   state_n = space_ok ? START : SPACE;
            START:   state_n = rd_busy ? WAIT : START;
            WAIT:    state_n = rd_busy ? WAIT : (sec_left == 16'd1 ? DONE : SPACE);
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            alive       <= 1'b0;
            cur_addr    <= '0;
            sec_left    <= '0;
            word_cnt    <= '0;
            rd_sec_addr <= '0;
            err         <= 1'b0;
        end else begin
            alive    <= 1'b1;
            cur_addr <= accept ? req_sec_addr : sec_end ? cur_addr + 32'd1 : cur_addr;
            sec_left <= accept ? req_sec_cnt : sec_end ? sec_left - 16'd1 : sec_left;
            word_cnt <= state == SPACE ? '0 : word_cnt + 8'(rd_val_en);
            if (state == SPACE && space_ok) rd_sec_addr <= cur_addr;
            err <= (err && !accept) || (sec_end && word_cnt != 8'(SEC_WORDS)) || (rd_val_en && full);
        end
    end
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
        end else begin
            if (push && !bypass) wr_ptr <= wr_ptr + 1'b1;
            if (load && !mem_empty) rd_ptr <= rd_ptr + 1'b1;
            if (load) m_valid <= !mem_empty || push;
            if (load && (!mem_empty || push)) {m_last, m_data} <= !mem_empty ? mem[rd_ptr] : {last_in, din};
            fifo_level <= fifo_level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end
    always_ff @(posedge clk_ref) begin
        if (push && !bypass) mem[wr_ptr] <= {last_in, din};
    end
endmodule

// File: tb/tb_sd_sec_stream.sv
// tb_sd_sec_stream: directed requests with a randomized reader/consumer, checked against a word-queue model.
module tb_sd_sec_stream;
    localparam int SW = 128;
    logic        clk_ref = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rd_busy = 1'b0, rd_val_en = 1'b0, m_ready = 1'b0;
    logic        req_ready, rd_start_en, m_valid, m_last, xfer_done, err;
    logic [31:0] req_sec_addr = '0, rd_val_data = '0, rd_sec_addr, m_data;
    logic [15:0] req_sec_cnt = '0;
    logic [8:0]  fifo_level;
    typedef struct packed {logic [31:0] d; logic l;} beat_t;
    beat_t       exp_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0, failures = 0, starts = 0, beats = 0, lasts = 0, done_cnt = 0;
    int          sec_idx = 0, sec_len = SW, cur_cnt = 0, ready_mode = 0, dmode = 0;
    logic [31:0] last_beat = '0;
    logic        hold_v = 1'b0;
    logic [33:0] hold_d = '0;

    sd_sec_stream dut (
        .clk_ref(clk_ref), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_sec_addr(req_sec_addr), .req_sec_cnt(req_sec_cnt), .rd_start_en(rd_start_en),
        .rd_sec_addr(rd_sec_addr), .rd_busy(rd_busy), .rd_val_en(rd_val_en), .rd_val_data(rd_val_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .xfer_done(xfer_done), .err(err), .fifo_level(fifo_level));

    always #5 clk_ref = ~clk_ref;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bus_order(input logic [31:0] w);
`ifdef SD_SEC_STREAM_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    initial forever begin
        @(posedge clk_ref);
        #1 m_ready = (ready_mode == 2) ? 1'($urandom_range(1)) : (ready_mode == 1);
    end

    // Reader model: edge-triggered start, busy three cycles later, words with random gaps.
    initial begin : reader
        logic [31:0] w;
        forever begin
            @(negedge clk_ref);
            if (rst_n && rd_start_en) begin
                starts++;
                addr_q.push_back(rd_sec_addr);
                chk("start_space", 64'(fifo_level <= 9'd128), 64'(1));
                repeat (3) @(posedge clk_ref);
                #1 rd_busy = 1'b1;
                for (int i = 0; i < sec_len; i++) begin
                    while ($urandom_range(3) == 0) begin
                        @(posedge clk_ref);
                        #1 rd_val_en = 1'b0;
                    end
                    @(posedge clk_ref);
                    w = dmode == 1 ? 32'(i) : dmode == 2 ? 32'hAABBCCDD : $urandom;
                    #1 rd_val_en = 1'b1;
                    rd_val_data = w;
                    exp_q.push_back('{bus_order(w), sec_idx == cur_cnt - 1 && i == SW - 1 && sec_len == SW});
                end
                @(posedge clk_ref);
                #1 rd_val_en = 1'b0;
                @(posedge clk_ref);
                #1 rd_busy = 1'b0;
                sec_idx++;
            end
        end
    end

    always @(negedge clk_ref) begin
        if (!rst_n) hold_v = 1'b0;
        else begin
            if (xfer_done) done_cnt++;
            if (hold_v) chk("hold", 64'({m_valid, m_last, m_data}), 64'(hold_d));
            if (m_valid && m_ready) begin
                beats++;
                if (m_last) lasts++;
                last_beat = m_data;
                if (exp_q.size() == 0) chk("beat_unexpected", 64'(1), 64'(0));
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_data), 64'(e.d));
                    chk("beat_last", 64'(m_last), 64'(e.l));
                end
            end
            hold_v = m_valid && !m_ready;
            hold_d = {1'b1, m_last, m_data};
        end
    end

    task automatic clear_stats();
        starts = 0; beats = 0; lasts = 0; done_cnt = 0;
        addr_q.delete();
    endtask

    task automatic do_req(input logic [31:0] a, input logic [15:0] c, input int len);
        clear_stats();
        sec_idx = 0; cur_cnt = int'(c); sec_len = len;
        @(posedge clk_ref);
        #1 req_valid = 1'b1; req_sec_addr = a; req_sec_cnt = c;
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        @(posedge clk_ref);
        #1 req_valid = 1'b0;
        @(negedge clk_ref);
        chk("req_ready_busy", 64'(req_ready), 64'(0));
        chk("done_after_accept", 64'(xfer_done), 64'(c == 16'd0));
        chk("err_cleared", 64'(err), 64'(0));
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt < 1 && t < budget) begin @(negedge clk_ref); t++; end
        chk("done_seen", 64'(done_cnt >= 1), 64'(1));
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < budget) begin @(negedge clk_ref); t++; end
        chk("drained", 64'(exp_q.size()), 64'(0));
        repeat (4) @(negedge clk_ref);
    endtask

    initial begin
        @(negedge clk_ref);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_start", 64'(rd_start_en), 64'(0));
        chk("rst_addr", 64'(rd_sec_addr), 64'(0));
        chk("rst_valid", 64'({m_valid, m_last, m_data}), 64'(0));
        chk("rst_flags", 64'({xfer_done, err}), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        @(posedge clk_ref);
        #1 rst_n = 1'b1;
        @(posedge clk_ref);
        @(negedge clk_ref);
        chk("req_ready_after_rst", 64'(req_ready), 64'(1));

        // single sector, index data
        dmode = 1; ready_mode = 2;
        do_req(32'h10, 16'd1, SW);
        wait_done(2000); drain(2000);
        chk("t1_starts", 64'(starts), 64'(1));
        chk("t1_addr", 64'(addr_q[0]), 64'(32'h10));
        chk("t1_beats", 64'(beats), 64'(128));
        chk("t1_lasts", 64'(lasts), 64'(1));
        chk("t1_done", 64'(done_cnt), 64'(1));
        chk("t1_err", 64'(err), 64'(0));

        // back-pressure
        dmode = 0; ready_mode = 0;
        do_req(32'h200, 16'd3, SW);
        repeat (900) @(negedge clk_ref);
        chk("bp_starts2", 64'(starts), 64'(2));
        chk("bp_level", 64'(fifo_level), 64'(256));
        chk("bp_valid", 64'(m_valid), 64'(1));
        ready_mode = 1;
        wait_done(3000); drain(3000);
        chk("bp_starts3", 64'(starts), 64'(3));
        chk("bp_beats", 64'(beats), 64'(384));
        chk("bp_lasts", 64'(lasts), 64'(1));
        chk("bp_addr2", 64'(addr_q[2]), 64'(32'h202));
        chk("bp_err", 64'(err), 64'(0));

        // zero count
        do_req(32'h55, 16'd0, SW);
        repeat (20) @(negedge clk_ref);
        chk("z_starts", 64'(starts), 64'(0));
        chk("z_done", 64'(done_cnt), 64'(1));
        chk("z_err", 64'(err), 64'(0));
        chk("z_valid", 64'(m_valid), 64'(0));

        // address wrap
        ready_mode = 2;
        do_req(32'hFFFFFFFF, 16'd2, SW);
        wait_done(3000); drain(3000);
        chk("w_starts", 64'(starts), 64'(2));
        chk("w_addr0", 64'(addr_q[0]), 64'(32'hFFFFFFFF));
        chk("w_addr1", 64'(addr_q[1]), 64'(32'h0));
        chk("w_beats", 64'(beats), 64'(256));
        chk("w_lasts", 64'(lasts), 64'(1));

        // short sector
        do_req(32'h77, 16'd1, 100);
        wait_done(2000); drain(2000);
        chk("s_err", 64'(err), 64'(1));
        chk("s_beats", 64'(beats), 64'(100));
        chk("s_lasts", 64'(lasts), 64'(0));
        chk("s_done", 64'(done_cnt), 64'(1));
        repeat (10) @(negedge clk_ref);
        chk("s_err_sticky", 64'(err), 64'(1));

        // byte order, also clears err
        dmode = 2;
        do_req(32'h88, 16'd1, SW);
        wait_done(2000); drain(2000);
        chk("b_err", 64'(err), 64'(0));
        chk("b_beats", 64'(beats), 64'(128));
`ifdef SD_SEC_STREAM_BSWAP_EN
        chk("b_word", 64'(last_beat), 64'(32'hDDCCBBAA));
`else
        chk("b_word", 64'(last_beat), 64'(32'hAABBCCDD));
`endif

        // reset mid-transfer
        dmode = 0; ready_mode = 0;
        do_req(32'h99, 16'd2, SW);
        repeat (80) @(negedge clk_ref);
        chk("mr_level_pre", 64'(fifo_level != 9'd0), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mr_level", 64'(fifo_level), 64'(0));
        chk("mr_out", 64'({m_valid, m_last, m_data}), 64'(0));
        chk("mr_ctl", 64'({req_ready, rd_start_en, xfer_done, err}), 64'(0));
        chk("mr_addr", 64'(rd_sec_addr), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
